regb_fifo_flags: RTL

- Parametrised register-based fall-through FIFO; next generation of the team's shift-register FIFO.
- Adds:
  - a fill-level output
  - programmable almost-full and almost-empty thresholds
  - defined simultaneous push/pop at full and at empty
- Built from a chain of per-slot register stages with valid bits. The head is always presented on rdata.
- Sits between producer/consumer blocks that need early back-pressure.

---
 rtl/regb_fifo_pkg.sv | 21 ++
 rtl/regb_fifo_stage.sv | 45 ++++
 rtl/regb_fifo_flags.sv | 119 +++++++++++
 3 files changed

// File: rtl/regb_fifo_pkg.sv
// Shared constants and width helpers for the register-based fall-through FIFO.
package regb_fifo_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_WIDTH = 8;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Level must represent 0..DEPTH inclusive.
    function automatic int lvl_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/regb_fifo_stage.sv
// One FIFO slot: data register plus valid bit, loaded from wdata (tail insert) or from the
// next slot (shift toward head). Tail insert wins when both are requested; res_n clears synchronously.
module regb_fifo_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             ld_wdata,
    input  logic             ld_up,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] up_dat,
    input  logic             up_vld,
    output logic [WIDTH-1:0] dat,
    output logic             vld
);

    logic [WIDTH-1:0] dat_q, dat_d;
    logic             vld_q, vld_d;

    always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        if (ld_wdata) begin
            dat_d = wdata;
            vld_d = 1'b1;
        end else if (ld_up) begin
            dat_d = up_dat;
            vld_d = up_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            dat_q <= '0;
            vld_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
        end
    end

    assign dat = dat_q;
    assign vld = vld_q;

endmodule

// File: rtl/regb_fifo_flags.sv
// Register-based fall-through FIFO with fill level and almost-full/almost-empty flags.
// Optional sticky overflow/underflow errors with err_clr when REGB_FIFO_ERR_EN is defined.
module regb_fifo_flags
    import regb_fifo_pkg::*;
#(
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int AF_LEVEL = DEPTH - 1,
    parameter  int AE_LEVEL = 1,
    localparam int LVL_W    = lvl_width(DEPTH)
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [WIDTH-1:0] wdata,
    input  logic             shift_in,
    input  logic             shift_out,
`ifdef REGB_FIFO_ERR_EN
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow,
`endif
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] stg_dat [DEPTH];
    logic [DEPTH-1:0] stg_vld;
    logic [DEPTH-1:0] ld_wdata;
    logic             push_ok;
    logic             pop_ok;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] ins_idx;

    // The head valid bit gates the pop; it always agrees with level_q != 0.
    always_comb begin
        pop_ok  = shift_out & stg_vld[0];
        push_ok = shift_in & (~full | shift_out);
        ins_idx = level_q - {{(LVL_W-1){1'b0}}, pop_ok};
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - 1'b1;
        end
        for (int k = 0; k < DEPTH; k++) begin
            ld_wdata[k] = push_ok && (ins_idx == LVL_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // Empty slots hold zero, so shifting from beyond the tail keeps rdata at 0 once drained.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] up_dat;
        logic             up_vld;
        if (k == DEPTH - 1) begin : g_last
            assign up_dat = '0;
            assign up_vld = 1'b0;
        end else begin : g_mid
            assign up_dat = stg_dat[k+1];
            assign up_vld = stg_vld[k+1];
        end
        regb_fifo_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (clk),
            .res_n    (res_n),
            .ld_wdata (ld_wdata[k]),
            .ld_up    (pop_ok),
            .wdata    (wdata),
            .up_dat   (up_dat),
            .up_vld   (up_vld),
            .dat      (stg_dat[k]),
            .vld      (stg_vld[k])
        );
    end

    assign rdata        = stg_dat[0];
    assign level        = level_q;
    assign empty        = (level_q == '0);
    assign full         = (level_q == LVL_W'(DEPTH));
    assign almost_empty = (level_q <= LVL_W'(AE_LEVEL));
    assign almost_full  = (level_q >= LVL_W'(AF_LEVEL));

`ifdef REGB_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error event in the clearing cycle keeps the flag set.
    always_comb begin
        overflow_d  = (overflow_q & ~err_clr) | (shift_in & full & ~shift_out);
        underflow_d = (underflow_q & ~err_clr) | (shift_out & empty);
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
